// File: rtl/ofdm_cp_serializer.sv
// ofdm_cp_serializer
//
// Takes one OFDM symbol (8 parallel complex time-domain samples from the
// IFFT modulator) per input handshake, optionally prepends a cyclic prefix,
// and streams the symbol out one complex sample per cycle under
// valid/ready flow control. An active buffer plus one pending buffer allow
// gap-free back-to-back symbols.
//
// Build option: define OFDM_CP_SERIALIZER_CP_EN to insert a cyclic prefix
// of CP_LEN samples (active[8-CP_LEN..7]) ahead of each body. Without it,
// symbols are 8 samples and CP_LEN is ignored.
//
// Parameters
//   WIDTH      bit width of each real/imag sample
//   CP_LEN     cyclic prefix length in samples (1..7)
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   parallel symbol present on in_re/in_im
//   in_ready   symbol can be captured this cycle (registered)
//   in_re      8 signed real parts, sample k at [WIDTH*(k+1)-1 : WIDTH*k]
//   in_im      8 signed imaginary parts, same packing
//   out_valid  out_re/out_im hold a valid sample
//   out_ready  downstream accepts the sample this cycle
//   out_re     serial real sample
//   out_im     serial imaginary sample
//   out_first  first sample of a symbol (first CP sample when CP enabled)
//   out_last   body sample 7
//   sym_count  fully transmitted symbols, wraps at 65535 -> 0

module ofdm_cp_serializer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CP_LEN = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*WIDTH-1:0]        in_re,
    input  logic [8*WIDTH-1:0]        in_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_re,
    output logic signed [WIDTH-1:0]   out_im,
    output logic                      out_first,
    output logic                      out_last,
    output logic [15:0]               sym_count
);

    if (CP_LEN < 1 || CP_LEN > 7) begin : g_bad_cp_len
        $error("ofdm_cp_serializer: CP_LEN must be in 1..7");
    end

`ifdef OFDM_CP_SERIALIZER_CP_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFIX,
        S_BODY
    } state_t;

    localparam state_t     START_STATE = S_PREFIX;
    localparam logic [2:0] START_IDX   = 3'(8 - CP_LEN);
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY
    } state_t;

    localparam state_t     START_STATE = S_BODY;
    localparam logic [2:0] START_IDX   = 3'd0;
`endif

    state_t                  r_state;
    logic [2:0]              r_idx;
    logic [WIDTH-1:0]        r_act_re  [8];
    logic [WIDTH-1:0]        r_act_im  [8];
    logic [WIDTH-1:0]        r_pend_re [8];
    logic [WIDTH-1:0]        r_pend_im [8];
    logic                    r_pend_full;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [WIDTH-1:0] r_out_re;
    logic signed [WIDTH-1:0] r_out_im;
    logic                    r_out_first;
    logic                    r_out_last;
    logic [15:0]             r_sym_count;

    logic [WIDTH-1:0]        w_in_re  [8];
    logic [WIDTH-1:0]        w_in_im  [8];
    logic [WIDTH-1:0]        w_src_re [8];
    logic [WIDTH-1:0]        w_src_im [8];
    logic                    w_cap;
    logic                    w_hs;
    logic                    w_last_hs;
    logic                    w_load_new;
    logic                    w_to_pend;
    logic                    w_pend_full_nxt;
    logic [2:0]              w_idx_inc;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign sym_count = r_sym_count;

    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            w_in_re[k]  = in_re[WIDTH*k +: WIDTH];
            w_in_im[k]  = in_im[WIDTH*k +: WIDTH];
            // Next symbol into active: the waiting one if present, otherwise
            // the one being captured right now (pending is always empty in IDLE).
            w_src_re[k] = r_pend_full ? r_pend_re[k] : w_in_re[k];
            w_src_im[k] = r_pend_full ? r_pend_im[k] : w_in_im[k];
        end
    end

    always_comb begin
        w_cap      = in_valid && r_in_ready;
        w_hs       = r_out_valid && out_ready;
        w_last_hs  = w_hs && (r_state == S_BODY) && (r_idx == 3'd7);
        w_idx_inc  = r_idx + 3'd1;
        // A capture coinciding with the final handshake and an empty pending
        // buffer is promoted straight into active on the same edge.
        w_load_new = ((r_state == S_IDLE) && w_cap) ||
                     (w_last_hs && (r_pend_full || w_cap));
        w_to_pend  = w_cap && (r_state != S_IDLE) && !(w_last_hs && !r_pend_full);

        w_pend_full_nxt = r_pend_full;
        if (w_to_pend) begin
            w_pend_full_nxt = 1'b1;
        end else if (w_last_hs) begin
            w_pend_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_pend_full <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_sym_count <= '0;
        end else begin
            r_pend_full <= w_pend_full_nxt;
            // Driven from the next-state flag so a full pending buffer can
            // never be overwritten by a capture one cycle later.
            r_in_ready  <= !w_pend_full_nxt;

            if (w_to_pend) begin
                for (int unsigned k = 0; k < 8; k++) begin
                    r_pend_re[k] <= w_in_re[k];
                    r_pend_im[k] <= w_in_im[k];
                end
            end

            if (w_last_hs) begin
                r_sym_count <= r_sym_count + 16'd1;
            end

            if (w_load_new) begin
                for (int unsigned k = 0; k < 8; k++) begin
                    r_act_re[k] <= w_src_re[k];
                    r_act_im[k] <= w_src_im[k];
                end
                r_state     <= START_STATE;
                r_idx       <= START_IDX;
                r_out_valid <= 1'b1;
                r_out_re    <= w_src_re[START_IDX];
                r_out_im    <= w_src_im[START_IDX];
                r_out_first <= 1'b1;
                r_out_last  <= 1'b0;
            end else if (w_last_hs) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_out_first <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_hs) begin
                r_out_first <= 1'b0;
`ifdef OFDM_CP_SERIALIZER_CP_EN
                if ((r_state == S_PREFIX) && (r_idx == 3'd7)) begin
                    r_state    <= S_BODY;
                    r_idx      <= '0;
                    r_out_re   <= r_act_re[0];
                    r_out_im   <= r_act_im[0];
                    r_out_last <= 1'b0;
                end else
`endif
                begin
                    r_idx      <= w_idx_inc;
                    r_out_re   <= r_act_re[w_idx_inc];
                    r_out_im   <= r_act_im[w_idx_inc];
                    r_out_last <= (r_state == S_BODY) && (r_idx == 3'd6);
                end
            end
        end
    end

endmodule

// File: tb/tb_ofdm_cp_serializer.sv
// Directed self-checking bench for ofdm_cp_serializer. Expected sample
// sequences follow the build: with OFDM_CP_SERIALIZER_CP_EN defined the
// symbol carries a 2-sample prefix, otherwise it is the bare 8-sample body.

module tb_ofdm_cp_serializer;

`ifdef OFDM_CP_SERIALIZER_CP_EN
    localparam int CPL    = 2;
    localparam int START  = 6;
`else
    localparam int CPL    = 0;
    localparam int START  = 0;
`endif
    localparam int SYMLEN = 8 + CPL;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_re;
    logic [127:0]       in_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               out_first;
    logic               out_last;
    logic [15:0]        sym_count;

    int n_tests = 0;
    int n_fail  = 0;

    ofdm_cp_serializer #(
        .WIDTH  (16),
        .CP_LEN (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_first (out_first),
        .out_last  (out_last),
        .sym_count (sym_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_sym(input int base);
        for (int k = 0; k < 8; k++) begin
            in_re[k*16 +: 16] = 16'(base + k);
            in_im[k*16 +: 16] = 16'(-(base + k));
        end
    endtask

    // Position p within a transmitted symbol -> body sample index.
    function automatic int exp_idx(input int p);
        return (p < CPL) ? (8 - CPL + p) : (p - CPL);
    endfunction

`ifdef OFDM_CP_SERIALIZER_CP_EN
    int exp1 [SYMLEN] = '{7, 8, 1, 2, 3, 4, 5, 6, 7, 8};
`else
    int exp1 [SYMLEN] = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif

    initial begin
        int  q;
        int  gaps;
        int  offered;
        bit  started;
        bit  cap;
        bit  found;
        bit  pat [4];

        pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_re    = '0;
        in_im    = '0;

        // Reset state
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_re",    out_re,    0);
        check("rst_out_im",    out_im,    0);
        check("rst_first",     out_first, 0);
        check("rst_last",      out_last,  0);
        check("rst_sym_count", sym_count, 0);
        reset = 1'b0;
        step();
        check("rel_in_ready",  in_ready,  1);
        check("rel_out_valid", out_valid, 0);

        // Single symbol, re[k]=k+1, im[k]=-(k+1)
        set_sym(1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int p = 0; p < SYMLEN; p++) begin
            check("s1_valid", out_valid, 1);
            check("s1_re",    out_re,    exp1[p]);
            check("s1_im",    out_im,    -exp1[p]);
            check("s1_first", out_first, (p == 0) ? 1 : 0);
            check("s1_last",  out_last,  (p == SYMLEN - 1) ? 1 : 0);
            step();
        end
        check("s1_idle",      out_valid, 0);
        check("s1_sym_count", sym_count, 1);

        // Three symbols offered continuously
        q = 0; gaps = 0; offered = 0; started = 1'b0;
        set_sym(10);
        in_valid = 1'b1;
        for (int c = 0; c < 80 && q < 3 * SYMLEN; c++) begin
            cap = in_valid && in_ready;
            if (out_valid) begin
                check("s2_re",    out_re,    10 * (q / SYMLEN + 1) + exp_idx(q % SYMLEN));
                check("s2_first", out_first, (q % SYMLEN == 0) ? 1 : 0);
                check("s2_last",  out_last,  (q % SYMLEN == SYMLEN - 1) ? 1 : 0);
                q++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            step();
            if (cap) begin
                offered++;
                if (offered == 2) check("s2_in_ready_low", in_ready, 0);
                if (offered < 3) set_sym(10 * (offered + 1));
                else             in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("s2_samples",   q,         3 * SYMLEN);
        check("s2_gaps",      gaps,      0);
        check("s2_sym_count", sym_count, 4);

        // Backpressure pattern 1,0,0,1
        set_sym(40);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        q = 0;
        for (int c = 0; c < 60 && q < SYMLEN; c++) begin
            out_ready = pat[c % 4];
            if (out_valid) begin
                check("s3_re",    out_re,    40 + exp_idx(q));
                check("s3_im",    out_im,    -(40 + exp_idx(q)));
                check("s3_first", out_first, (q == 0) ? 1 : 0);
                check("s3_last",  out_last,  (q == SYMLEN - 1) ? 1 : 0);
                if (out_ready) q++;
            end
            step();
        end
        out_ready = 1'b1;
        check("s3_samples",   q,         SYMLEN);
        check("s3_idle",      out_valid, 0);
        check("s3_sym_count", sym_count, 5);

        // Capture on the same cycle as the out_last handshake
        set_sym(50);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (out_valid && out_last) found = 1'b1;
            else                       step();
        end
        check("s4_last_seen", found, 1);
        set_sym(60);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("s4_valid",    out_valid, 1);
        check("s4_first",    out_first, 1);
        check("s4_re",       out_re,    60 + START);
        check("s4_in_ready", in_ready,  1);
        for (int c = 0; c < 20 && out_valid; c++) step();
        check("s4_idle",      out_valid, 0);
        check("s4_sym_count", sym_count, 7);

        // Reset on the 4th sample with a symbol pending
        set_sym(70);
        in_valid = 1'b1;
        step();
        set_sym(80);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("s5_pre_re", out_re, 70 + exp_idx(3));
        reset = 1'b1;
        step();
        check("s5_rst_valid",     out_valid, 0);
        check("s5_rst_sym_count", sym_count, 0);
        check("s5_rst_in_ready",  in_ready,  0);
        reset = 1'b0;
        step();
        check("s5_rel_in_ready",  in_ready,  1);
        check("s5_rel_valid",     out_valid, 0);
        set_sym(90);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int p = 0; p < SYMLEN; p++) begin
            check("s5_valid", out_valid, 1);
            check("s5_re",    out_re,    90 + exp_idx(p));
            check("s5_first", out_first, (p == 0) ? 1 : 0);
            check("s5_last",  out_last,  (p == SYMLEN - 1) ? 1 : 0);
            step();
        end
        check("s5_idle",      out_valid, 0);
        check("s5_sym_count", sym_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_cp_serializer.md
# ofdm_cp_serializer

- Downstream of the 8-point IFFT modulator.
- Accepts one OFDM symbol per handshake, as 8 parallel complex time-domain samples.
- Prepends a cyclic prefix and streams the symbol out one complex sample per cycle under valid/ready flow control.
- Double-buffered, so a new symbol can be captured while the previous one is still draining. This allows gap-free back-to-back symbols toward the DAC/channel interface.

## Interface
- `WIDTH`, 16: bit width of each real/imag sample; matches the modulator `OUTPUT_WIDTH`.
- `CP_LEN`, 2: cyclic prefix length in samples; legal range 1..7.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: parallel symbol present on `in_re`/`in_im`.
- `in_ready` out 1: block can capture a symbol this cycle; registered.
- `in_re` in 8*WIDTH: signed real parts; sample k at bits `[WIDTH*(k+1)-1 : WIDTH*k]`.
- `in_im` in 8*WIDTH: signed imaginary parts, same packing.
- `out_valid` out 1: `out_re`/`out_im` hold a valid sample.
- `out_ready` in 1: downstream accepts the sample this cycle.
- `out_re`, `out_im` out WIDTH: signed serial sample.
- `out_first` out 1: high on the first sample of a symbol (first CP sample).
- `out_last` out 1: high on sample 7 of the symbol body.
- `sym_count` out 16: count of fully transmitted symbols; wraps at 65535 -> 0.

## Operation
- Storage: `active` buffer (symbol being streamed) plus `pending` buffer (one waiting symbol), each with a full flag.
- Capture occurs on `in_valid && in_ready`:
  - If `active` is empty, the symbol loads into `active`.
  - Otherwise it loads into `pending`.
- Samples are copied verbatim; no scaling or rounding.
- `in_ready` = NOT `pending` full, registered.
  - It is never derived combinationally from `out_ready`.
- State machine:
  - `IDLE`: `active` empty, `out_valid`=0. On capture -> `PREFIX`, index = 8-CP_LEN.
  - `PREFIX`: emits `active[8-CP_LEN .. 7]` in order. After the `CP_LEN`-th output handshake -> `BODY`, index = 0.
  - `BODY`: emits `active[0..7]`.
    - On the index-7 handshake, `sym_count` increments.
    - If `pending` is full: `pending` moves to `active`, `pending` is freed, -> `PREFIX`.
    - Else -> `IDLE`.
- A sample index advances only on an output handshake (`out_valid && out_ready`).
- While `out_valid && !out_ready`, `out_re`/`out_im`/`out_first`/`out_last` hold stable.
- Simultaneous capture and last-sample handshake, with `pending` empty: the new symbol goes to `pending` and is promoted to `active` in the same edge. Next cycle is `PREFIX` with the new data, no bubble.
- Reset mid-symbol: the partial symbol and `pending` are discarded, and `sym_count` is cleared. No truncated-symbol marker is generated.

## Timing
- Reset values:
  - `out_valid`=0, `out_re`=`out_im`=0, `out_first`=`out_last`=0, `sym_count`=0, state `IDLE`, both buffers empty.
  - `in_ready`=0 while `reset` is high, and 1 from the first cycle after release.
- Latency: capture at edge N (from `IDLE`) -> first prefix sample valid in cycle N+1.
- Throughput: 8+CP_LEN cycles per symbol with `out_ready` held high.
  - Back-to-back symbols stream with zero idle cycles when `pending` is loaded before the previous `out_last` handshake.
- `in_ready` falls the cycle after `pending` fills.
  - It rises the cycle after `pending` is promoted.
- `sym_count` updates the cycle after the `out_last` handshake.

## Configuration
- `OFDM_CP_SERIALIZER_CP_EN` defined:
  - Cyclic prefix is inserted as above; `CP_LEN` is used.
  - Symbol = 8+CP_LEN samples; `out_first` marks the first CP sample.
- Not defined:
  - `PREFIX` state is removed and `CP_LEN` is ignored.
  - Capture goes directly to `BODY`; symbol = 8 samples; `out_first` marks sample 0.
- Handshake, latency and reset rules are otherwise identical.

## Test plan
- Single symbol, `in_re[k]`=k+1, `in_im[k]`=-(k+1), `CP_LEN`=2, `out_ready`=1:
  - Cycles 1..10 output re = 7,8,1,2,3,4,5,6,7,8.
  - `out_first` on cycle 1, `out_last` on cycle 10, `sym_count`=1 afterward.
- Three symbols offered continuously with `out_ready`=1:
  - 30 consecutive valid samples with no gap.
  - `in_ready` low while `pending` is full.
  - `sym_count`=3.
- `out_ready` toggled 1,0,0,1 repeatedly during a symbol: outputs hold stable across stalls, and no sample is dropped or duplicated.
- `in_valid` asserted on the same cycle as the `out_last` handshake: the next `out_first` appears the following cycle with the new symbol's sample 6.
- Reset asserted on the 4th sample:
  - Next cycle `out_valid`=0, `sym_count`=0.
  - `in_ready`=1 the cycle after release.
  - The next symbol streams complete from its CP.
- Build without `OFDM_CP_SERIALIZER_CP_EN`: the same stimulus as the first scenario yields exactly 1..8, with `out_first` on the 1 and `out_last` on the 8.
